lsu_byte_sequencer: RTL and testbench

Load/store sequencer between the processor's execute stage and the 8-bit data memory. It accepts one byte, halfword or word load/store request through a valid/ready handshake. It splits the request into consecutive single-byte memory accesses in little-endian order, assembles and sign/zero-extends load data, and returns one response per request. It drives the data memory's write-enable, address and write-data inputs and consumes its combinational read-data output.

---
 rtl/lsu_byte_sequencer.sv | 124 ++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: splits byte/half/word requests into single-byte
// little-endian accesses on an 8-bit data memory and returns one response each.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_wd,
  input  logic [7:0]        mem_rd,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request transfers on an edge with req_valid & req_ready,
  // a response retires on an edge with rsp_valid & rsp_ready; req_ready is
  // high only in IDLE, so at most one request is in flight.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt;
  logic [31:0]       buf_q;
  logic              err_q;
  logic [1:0]        last_cnt;
  logic              last;
  logic [31:0]       ld_data;

  assign last_cnt = (size_q == 2'd0) ? 2'd0 : (size_q == 2'd1) ? 2'd1 : 2'd3;
  assign last     = (cnt == last_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      base_q  <= '0;
      wdata_q <= 32'd0;
      cnt     <= 2'd0;
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sign_q  <= req_sign;
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 2'd0;
            buf_q   <= 32'd0;
            err_q   <= (req_size == 2'd3);
          end
        end
        ACCESS: begin
          if (!we_q) buf_q[{cnt, 3'b000} +: 8] <= mem_rd;
          if (!last) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (req_size == 2'd3) ? RESP : ACCESS;
      ACCESS:  if (last) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Extension bit is the top loaded bit of the access width.
  always_comb begin
    ld_data = buf_q;
    case (size_q)
      2'd0:    ld_data = {{24{sign_q & buf_q[7]}}, buf_q[7:0]};
      2'd1:    ld_data = {{16{sign_q & buf_q[15]}}, buf_q[15:0]};
      default: ld_data = buf_q;
    endcase
  end

  // mem_* decode only from registered state; rst gates req_ready while held.
  always_comb begin
    req_ready = rst & (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) & err_q;
    rsp_rdata = (state == RESP && !we_q && !err_q) ? ld_data : 32'd0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = 8'd0;
    if (state == ACCESS) begin
      mem_we = we_q;
      mem_a  = base_q + ADDR_W'(cnt);
      mem_wd = we_q ? wdata_q[{cnt, 3'b000} +: 8] : 8'd0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: transaction-level model predicts every cycle's
// outputs into a queue that a negedge compare process checks.
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [7:0]  mem_a, mem_wd, mem_rd;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  dmem [256];
  logic [7:0]  ref_mem [256];
  logic [51:0] exp_q [$];
  logic [31:0] last_rsp;
  logic        last_err;

  always #5 clk = ~clk;

  lsu_byte_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // Data memory: byte 0 reads as zero and ignores writes.
  assign mem_rd = (mem_a == 8'h00) ? 8'h00 : dmem[mem_a];

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      dmem[i] = v;
      ref_mem[i] = v;
    end
    forever begin
      @(posedge clk);
      if (mem_we && mem_a != 8'h00) dmem[mem_a] <= mem_wd;
    end
  end

  function automatic logic [51:0] mk(logic rr, logic rv, logic re, logic [31:0] rd,
                                      logic we, logic [7:0] a, logic [7:0] wd);
    return {rr, rv, re, rd, we, a, wd};
  endfunction

  function automatic logic [31:0] ext(logic [31:0] v, int n, logic s);
    logic [31:0] m;
    logic [31:0] r;
    m = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    r = v & m;
    if (s && n < 4 && v[8 * n - 1]) r = r | ~m;
    return r;
  endfunction

  // Compare process: one expectation per clock cycle, sampled mid-cycle.
  always @(negedge clk) begin
    logic [51:0] e, g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL outputs cyc%0d got rr=%b rv=%b err=%b rd=%h we=%b a=%h wd=%h exp rr=%b rv=%b err=%b rd=%h we=%b a=%h wd=%h",
                 cyc, g[51], g[50], g[49], g[48:17], g[16], g[15:8], g[7:0],
                 e[51], e[50], e[49], e[48:17], e[16], e[15:8], e[7:0]);
      end
    end
    if (rsp_valid) begin
      last_rsp = rsp_rdata;
      last_err = rsp_err;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic step(input logic [51:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      rsp_ready = 1'($urandom);
      step(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0));
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [7:0] addr, input logic [31:0] wdata, input int hold);
    int n;
    logic [31:0] rd;
    logic [7:0]  a;
    n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    rd = 32'd0;
    if (size != 2'd3 && !we) begin
      for (int i = 0; i < n; i++) begin
        a = 8'(addr + i);
        rd = rd | (32'((a == 8'h00) ? 8'h00 : ref_mem[a]) << (8 * i));
      end
      rd = ext(rd, n, sign);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    step(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0));
    req_valid = 1'($urandom_range(0, 1));
    req_we = 1'($urandom); req_size = 2'($urandom); req_addr = 8'($urandom);
    req_wdata = $urandom;
    if (size != 2'd3) begin
      for (int i = 0; i < n; i++) begin
        a = 8'(addr + i);
        rsp_ready = 1'($urandom);
        step(mk(1'b0, 1'b0, 1'b0, 32'd0, we, a, we ? wdata[8 * i +: 8] : 8'd0));
        if (we && a != 8'h00) ref_mem[a] = wdata[8 * i +: 8];
      end
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      step(mk(1'b0, 1'b1, size == 2'd3, rd, 1'b0, 8'd0, 8'd0));
    end
    rsp_ready = 1'b1;
    step(mk(1'b0, 1'b1, size == 2'd3, rd, 1'b0, 8'd0, 8'd0));
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 8'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    last_rsp = 32'd0; last_err = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(52'd0);
    rst = 1'b1;
    idle(2);

    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'h1122_3344, 0);
    chk("store_word_mem", {dmem[8'h13], dmem[8'h12], dmem[8'h11], dmem[8'h10]}, 32'h1122_3344);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0);
    chk("load_word", last_rsp, 32'h1122_3344);

    do_req(1'b1, 2'd0, 1'b0, 8'h20, 32'h0000_0080, 0);
    do_req(1'b0, 2'd0, 1'b1, 8'h20, 32'h0, 0);
    chk("load_byte_signed", last_rsp, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b0, 8'h20, 32'h0, 1);
    chk("load_byte_unsigned", last_rsp, 32'h0000_0080);

    do_req(1'b1, 2'd1, 1'b0, 8'hFF, 32'h0000_BEEF, 0);
    chk("store_half_wrap", 32'(dmem[8'hFF]), 32'h0000_00EF);
    do_req(1'b0, 2'd1, 1'b0, 8'hFF, 32'h0, 0);
    chk("load_half_wrap", last_rsp, 32'h0000_00EF);

    idle(1);
    do_req(1'b0, 2'd3, 1'b0, 8'h40, 32'h0, 0);
    chk("err_flag", 32'(last_err), 32'd1);
    chk("err_rdata", last_rsp, 32'd0);

    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 3);
    chk("load_word_held", last_rsp, 32'h1122_3344);
    idle(1);

    // Abort a word store after its second byte has been written.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_sign = 1'b0;
    req_addr = 8'h30; req_wdata = 32'hA1B2_C3D4;
    step(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0));
    req_valid = 1'b0;
    step(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 8'h30, 8'hD4));
    ref_mem[8'h30] = 8'hD4;
    step(mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 8'h31, 8'hC3));
    ref_mem[8'h31] = 8'hC3;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        32'({req_ready, rsp_valid, rsp_err, mem_we, mem_a, mem_wd} | 22'(rsp_rdata != 0)), 32'd0);
    step(52'd0);
    step(52'd0);
    rst = 1'b1;
    idle(1);
    do_req(1'b0, 2'd2, 1'b0, 8'h30, 32'h0, 0);
    chk("reset_partial_store", last_rsp & 32'h0000_FFFF, 32'h0000_C3D4);

    for (int k = 0; k < 60; k++) begin
      logic [1:0] sz;
      logic [7:0] ad;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom_range(0, 31));
      idle($urandom_range(0, 2));
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom_range(0, 2));
    end
    idle(2);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
